alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Operand-latch + execute stage feeding the result/flag register. Captures operands A and B from the 4-bit data bus,
//  runs the op selected at start (1 cycle for ADD/SUB/AND, WIDTH+1 cycles for iterative MUL), then presents
//  registered res and Z/C/O/N with a 1-cycle done pulse. The result register captures on done.
// PARAMETERS
//  WIDTH  4  operand/result/bus width in bits
// PORTS
//  clk     in   1      system clock; all state updates on posedge
//  grst    in   1      global reset; synchronous, active-high
//  lrst    in   1      local reset; synchronous, active-high, same effect as grst
//  bus     in   WIDTH  data bus (read-only here)
//  rs1     in   1      latch bus into operand A this cycle
//  rs2     in   1      latch bus into operand B this cycle
//  op_sel  in   2      00 none, 01 ADD, 10 SUB (A-B), 11 MUL (macro on) / AND (macro off)
//  start   in   1      begin op_sel operation on current A, B
//  busy    out  1      operation in progress; start, rs1 and rs2 ignored while high
//  done    out  1      1-cycle pulse: res/flags valid from this cycle
//  res     out  WIDTH  registered result; holds until next done or reset
//  Z C O N out  1 each registered flags: zero, carry/borrow, signed overflow, negative
// BEHAVIOUR
//  Reset: grst|lrst at posedge -> state IDLE; A, B, res, Z, C, O, N, busy, done all 0. Mid-op reset aborts, no done.
//  FSM: IDLE -(start & op_sel!=00)-> EXEC (ADD/SUB/AND) or MUL; EXEC -> DONE; MUL -(WIDTH iterations)-> DONE; DONE -> IDLE.
//  start with op_sel==00 is ignored; state stays IDLE.
//  op_sel sampled only at start; later changes ignored until back in IDLE.
//  busy = 1 in EXEC and MUL; done = 1 only in DONE. res/flags update on the edge entering DONE.
//  Latency, start sampled at edge t: ADD/SUB/AND done high in cycle t+2; MUL done high in cycle t+WIDTH+2.
//  start in DONE is ignored. Back-to-back: next start accepted in the first IDLE cycle.
//  Operands: rs1/rs2 honoured only in IDLE or DONE. Both high in the same cycle -> A = B = bus.
//  rs and start in the same IDLE cycle: op uses the old operand values; the new value is visible to the next op.
//  ADD: {C,res} = A+B (WIDTH+1 bits). O = (A[msb]==B[msb]) & (res[msb]!=A[msb]).
//  SUB: res = A-B mod 2^WIDTH. C = borrow (A<B unsigned). O = (A[msb]!=B[msb]) & (res[msb]!=A[msb]).
//  AND: res = A&B; C = O = 0.
//  All ops: Z = (res==0); N = res[WIDTH-1].
// CONFIGURATION
//  ALU_MUL_EN defined: op 11 = unsigned shift-add multiply, 1 partial product per cycle, WIDTH cycles.
//   res = low WIDTH bits of A*B; C = (high WIDTH bits != 0); O = 0.
//  ALU_MUL_EN undefined: op 11 = single-cycle AND through EXEC; MUL state and multiplier logic are not built.
// STRUCTURE
//  Shared package alu_pkg:
//   - op encodings OP_NONE/OP_ADD/OP_SUB/OP_X11
//   - state enum IDLE/EXEC/MUL/DONE
//   - default WIDTH constant
//  Sub-module alu_mul_seq (instantiated only under ALU_MUL_EN):
//   - ports: load, A, B in; product[2*WIDTH-1:0], last out
//   - holds the iteration counter and the accumulator
// TESTING
//  1. bus=4'h7 rs1; bus=4'h1 rs2; op 01 start -> done at t+2, res=8, Z0 C0 O1 N1.
//  2. A=3, B=5, op 10 -> res=E, C=1 (borrow), O=0, N=1, Z=0.
//  3. A=F, B=1, op 01 -> res=0, Z=1, C=1, O=0. A=C, B=A, op 11 without macro -> res=8, C=0, O=0.
//  4. MUL_EN: A=5, B=3 -> busy for WIDTH+1 cycles, res=F, C=0. A=F, B=F -> res=1, C=1.
//  5. start during busy, rs1 during busy, op_sel changed mid-MUL -> all ignored, result unchanged.
//  6. lrst asserted mid-MUL -> next cycle all outputs 0, no done pulse; a fresh start then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execute stage: op select codes, FSM states, default width.
package alu_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_X11  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles after load.
// last_o pulses for one cycle once product_o holds the complete result.
module alu_mul_seq #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               last_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;
    logic               last_q;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            last_q   <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
            last_q   <= 1'b0;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                run_q  <= 1'b0;
                last_q <= 1'b1;
            end
        end else begin
            last_q <= 1'b0;
        end
    end

    assign product_o = acc_q;
    assign last_o    = last_q;

endmodule

// File: rtl/alu_exec.sv
// Operand latch + execute stage with registered result/flags and a one-cycle done pulse.
// Define ALU_MUL_EN to make op 11 an iterative multiply; otherwise op 11 is a single-cycle AND.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             grst,
    input  logic             lrst,
    input  logic [WIDTH-1:0] bus,
    input  logic             rs1,
    input  logic             rs2,
    input  logic [1:0]       op_sel,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             Z,
    output logic             C,
    output logic             O,
    output logic             N
);

    localparam int MSB = WIDTH - 1;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] res_q;
    logic             z_q, c_q, o_q, n_q;
    logic             busy_q, done_q;

    logic             rst;
    logic             accept;
    logic             finish;
    logic             mul_last;
    logic [WIDTH:0]   sum_ext, dif_ext;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c, fin_o;

    assign rst    = grst | lrst;
    assign accept = (state_q == IDLE) && start && (op_sel != OP_NONE);

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;

    // Loaded from the pre-edge operands, so an rs in the start cycle does not leak in.
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_i     (rst),
        .load_i    (accept && (op_sel == OP_X11)),
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (mul_prod),
        .last_o    (mul_last)
    );
`else
    assign mul_last = 1'b0;
`endif

    assign finish = (state_q == EXEC) || ((state_q == MUL) && mul_last);

    always_comb begin
        sum_ext = {1'b0, opa_q} + {1'b0, opb_q};
        dif_ext = {1'b0, opa_q} - {1'b0, opb_q};
        fin_res = opa_q & opb_q;
        fin_c   = 1'b0;
        fin_o   = 1'b0;
        case (op_q)
            OP_ADD: begin
                fin_res = sum_ext[WIDTH-1:0];
                fin_c   = sum_ext[WIDTH];
                fin_o   = (opa_q[MSB] == opb_q[MSB]) && (sum_ext[MSB] != opa_q[MSB]);
            end
            OP_SUB: begin
                fin_res = dif_ext[WIDTH-1:0];
                fin_c   = dif_ext[WIDTH];
                fin_o   = (opa_q[MSB] != opb_q[MSB]) && (dif_ext[MSB] != opa_q[MSB]);
            end
            default: ;
        endcase
`ifdef ALU_MUL_EN
        if (state_q == MUL) begin
            fin_res = mul_prod[WIDTH-1:0];
            fin_c   = |mul_prod[2*WIDTH-1:WIDTH];
            fin_o   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == IDLE) || (state_q == DONE)) begin
                if (rs1) a_q <= bus;
                if (rs2) b_q <= bus;
            end
            if (finish) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                res_q   <= fin_res;
                z_q     <= (fin_res == '0);
                c_q     <= fin_c;
                o_q     <= fin_o;
                n_q     <= fin_res[MSB];
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        // Snapshot operands so same-cycle rs writes only affect the next op.
                        op_q   <= op_e'(op_sel);
                        opa_q  <= a_q;
                        opb_q  <= b_q;
                        busy_q <= 1'b1;
`ifdef ALU_MUL_EN
                        state_q <= (op_sel == OP_X11) ? MUL : EXEC;
`else
                        state_q <= EXEC;
`endif
                    end
                    DONE:    state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
    assign Z    = z_q;
    assign C    = c_q;
    assign O    = o_q;
    assign N    = n_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: transaction-level reference model checked every cycle, directed literal cases, random traffic.
module tb_alu_exec;

    localparam int W = 4;
    localparam logic [W-1:0] MASK = {W{1'b1}};
`ifdef ALU_MUL_EN
    localparam int X11_LAT = W + 2;
`else
    localparam int X11_LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         grst = 1'b1, lrst = 1'b0;
    logic [W-1:0] bus = '0;
    logic         rs1 = 1'b0, rs2 = 1'b0, start = 1'b0;
    logic [1:0]   op_sel = 2'b00;
    logic         busy, done, Z, C, O, N;
    logic [W-1:0] res;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .grst(grst), .lrst(lrst), .bus(bus), .rs1(rs1), .rs2(rs2),
        .op_sel(op_sel), .start(start), .busy(busy), .done(done), .res(res),
        .Z(Z), .C(C), .O(O), .N(N)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sg(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    // Arithmetic meaning of each op, computed with integers.
    function automatic void calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic o);
        int full, s;
        full = 0; s = 0; c = 1'b0; o = 1'b0;
        case (op)
            2'b01: begin
                full = int'(a) + int'(b);
                s    = sg(a) + sg(b);
                c    = full >= (1 << W);
                o    = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            2'b10: begin
                full = int'(a) - int'(b);
                s    = sg(a) - sg(b);
                c    = a < b;
                o    = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            default: begin
`ifdef ALU_MUL_EN
                full = int'(a) * int'(b);
                c    = (full >> W) != 0;
`else
                full = int'(a & b);
`endif
            end
        endcase
        r = full[W-1:0];
    endfunction

    // Reference model: operands, pending result and cycles left until done.
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, p_res = '0;
    logic         m_z = 0, m_c = 0, m_o = 0, m_n = 0, p_c = 0, p_o = 0;
    logic         m_busy = 0, m_done = 0, new_done, take_ops;
    int           m_left = 0;

    always @(posedge clk) begin
        if (grst || lrst) begin
            m_a = '0; m_b = '0; m_res = '0;
            m_z = 0; m_c = 0; m_o = 0; m_n = 0;
            m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            take_ops = !m_busy;
            new_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    new_done = 1'b1;
                    m_res = p_res; m_c = p_c; m_o = p_o;
                    m_z = (p_res == 0); m_n = p_res[W-1];
                end
            end else if (!m_done && start && op_sel != 2'b00) begin
                calc(op_sel, m_a, m_b, p_res, p_c, p_o);
                m_busy = 1'b1;
                m_left = X11_LAT - 1;
                if (op_sel != 2'b11) m_left = 1;
            end
            m_done = new_done;
            if (take_ops) begin
                if (rs1) m_a = bus;
                if (rs2) m_b = bus;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle", {busy, done, res, Z, C, O, N}, {m_busy, m_done, m_res, m_z, m_c, m_o, m_n});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
        bus = a; rs1 = 1'b1; cyc(); rs1 = 1'b0;
        bus = b; rs2 = 1'b1; cyc(); rs2 = 1'b0;
    endtask

    // Runs one op and checks latency, busy length, result and flags against literals.
    // inj: poke start/rs1/op_sel in the first busy cycle; new_a >= 0: rs1 in the start cycle.
    task automatic run_op(input logic [1:0] op, input string nm, input logic [W-1:0] er,
                          input logic ez, input logic ec, input logic eo, input logic en,
                          input int elat, input bit inj, input int new_a);
        int n, nb;
        op_sel = op; start = 1'b1;
        if (new_a >= 0) begin bus = new_a[W-1:0]; rs1 = 1'b1; end
        cyc();
        start = 1'b0; rs1 = 1'b0;
        n = 1; nb = 0;
        if (inj) begin
            start = 1'b1; rs1 = 1'b1; bus = MASK; op_sel = op ^ 2'b11;
        end
        while (!done && n < 100) begin
            if (busy) nb++;
            cyc();
            start = 1'b0; rs1 = 1'b0;
            n++;
        end
        check({nm, "_done_seen"}, done, 1'b1);
        check({nm, "_latency"}, n, elat);
        check({nm, "_busy_cycles"}, nb, elat - 1);
        check({nm, "_res"}, res, er);
        check({nm, "_flags_zcon"}, {Z, C, O, N}, {ez, ec, eo, en});
        cyc();
        check({nm, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int seen_done;
        cyc();
        grst = 1'b0;
        chk_en = 1'b1;
        check("reset_res", res, '0);
        check("reset_ctl", {busy, done, Z, C, O, N}, 6'b0);

        load_ab(4'h7, 4'h1);
        run_op(2'b01, "add_7_1", 4'h8, 0, 0, 1, 1, 2, 0, -1);
        load_ab(4'h3, 4'h5);
        run_op(2'b10, "sub_3_5", 4'hE, 0, 1, 0, 1, 2, 0, -1);
        load_ab(4'hF, 4'h1);
        run_op(2'b01, "add_f_1", 4'h0, 1, 1, 0, 0, 2, 0, -1);
        load_ab(4'hC, 4'hA);
`ifdef ALU_MUL_EN
        run_op(2'b11, "mul_c_a", 4'h8, 0, 1, 0, 1, X11_LAT, 0, -1);
        load_ab(4'h5, 4'h3);
        run_op(2'b11, "mul_5_3", 4'hF, 0, 0, 0, 1, X11_LAT, 0, -1);
        load_ab(4'hF, 4'hF);
        run_op(2'b11, "mul_f_f", 4'h1, 0, 1, 0, 0, X11_LAT, 0, -1);
        load_ab(4'h5, 4'h3);
        run_op(2'b11, "mul_inj", 4'hF, 0, 0, 0, 1, X11_LAT, 1, -1);
`else
        run_op(2'b11, "and_c_a", 4'h8, 0, 0, 0, 1, X11_LAT, 0, -1);
`endif
        load_ab(4'h5, 4'h3);
        run_op(2'b01, "add_inj", 4'h8, 0, 0, 1, 1, 2, 1, -1);
        run_op(2'b01, "add_again", 4'h8, 0, 0, 1, 1, 2, 0, -1);
        run_op(2'b01, "add_rs_same", 4'h8, 0, 0, 1, 1, 2, 0, 1);
        run_op(2'b01, "add_new_a", 4'h4, 0, 0, 0, 0, 2, 0, -1);

        start = 1'b1; op_sel = 2'b00;
        cyc(); cyc();
        start = 1'b0;
        check("start_op00_ignored", {busy, done}, 2'b00);

        load_ab(4'h9, 4'h4);
        op_sel = 2'b11; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        lrst = 1'b1;
        cyc();
        lrst = 1'b0;
        check("lrst_outputs", {busy, done, res, Z, C, O, N}, '0);
        seen_done = 0;
        for (int i = 0; i < X11_LAT + 4; i++) begin
            if (done) seen_done++;
            cyc();
        end
        check("lrst_no_done", seen_done, 0);
        load_ab(4'h2, 4'h2);
        run_op(2'b01, "after_lrst", 4'h4, 0, 0, 0, 0, 2, 0, -1);

        for (int i = 0; i < 600; i++) begin
            bus    = 4'($urandom_range(0, 15));
            rs1    = ($urandom_range(0, 3) == 0);
            rs2    = ($urandom_range(0, 3) == 0);
            start  = ($urandom_range(0, 2) == 0);
            op_sel = 2'($urandom_range(0, 3));
            lrst   = ($urandom_range(0, 79) == 0);
            grst   = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rs1 = 0; rs2 = 0; start = 0; lrst = 0; grst = 0;
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
